multicycle_ctrl: RTL and testbench

- State-machine control unit of the multicycle CPU.
- Sequences each instruction through IF/ID/EXE/MEM/WB.
- Drives the 2-bit select codes of the datapath 4:1 selectors (PC source, register-destination source) plus all write enables and ALU control.
- Sits directly upstream of the PC-source selector.

---
 rtl/cpu_ctrl_pkg.sv | 80 ++++++++
 rtl/multicycle_ctrl_if.sv | 45 ++++
 rtl/ctrl_decode.sv | 105 ++++++++++
 rtl/multicycle_ctrl.sv | 60 ++++++
 tb/tb_multicycle_ctrl.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU control unit: states, opcodes,
// ALU codes, selector codes and the bundled control-word type.
package cpu_ctrl_pkg;

    localparam int OPW    = 6;
    localparam int RA_IDX = 31;

    typedef enum logic [2:0] {
        S_IF     = 3'd0,
        S_ID     = 3'd1,
        S_EXE_AL = 3'd2,
        S_EXE_BR = 3'd3,
        S_EXE_LS = 3'd4,
        S_MEM    = 3'd5,
        S_WB_AL  = 3'd6,
        S_WB_LD  = 3'd7
    } state_t;

    localparam logic [OPW-1:0] OP_ADD  = 6'b000000;
    localparam logic [OPW-1:0] OP_SUB  = 6'b000001;
    localparam logic [OPW-1:0] OP_ADDI = 6'b000010;
    localparam logic [OPW-1:0] OP_OR   = 6'b010000;
    localparam logic [OPW-1:0] OP_AND  = 6'b010001;
    localparam logic [OPW-1:0] OP_ORI  = 6'b010010;
    localparam logic [OPW-1:0] OP_SLT  = 6'b100110;
    localparam logic [OPW-1:0] OP_SW   = 6'b110000;
    localparam logic [OPW-1:0] OP_LW   = 6'b110001;
    localparam logic [OPW-1:0] OP_BEQ  = 6'b110100;
    localparam logic [OPW-1:0] OP_BNE  = 6'b110101;
    localparam logic [OPW-1:0] OP_J    = 6'b111000;
    localparam logic [OPW-1:0] OP_JR   = 6'b111001;
    localparam logic [OPW-1:0] OP_JAL  = 6'b111010;
    localparam logic [OPW-1:0] OP_HALT = 6'b111111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [1:0] PC_SEQ = 2'd0;
    localparam logic [1:0] PC_BR  = 2'd1;
    localparam logic [1:0] PC_JMP = 2'd2;
    localparam logic [1:0] PC_JR  = 2'd3;

    localparam logic [1:0] RD_RA = 2'd0;
    localparam logic [1:0] RD_RT = 2'd1;
    localparam logic [1:0] RD_RD = 2'd2;

    typedef struct packed {
        logic [1:0] pc_src;
        logic [1:0] reg_dst;
        logic       pc_write;
        logic       ir_write;
        logic       reg_write;
        logic       mem_write;
        logic       alu_src_a;
        logic       alu_src_b;
        logic       ext_sel;
        logic       db_src;
        logic       wr_pc4;
        logic [2:0] alu_op;
        logic       halted;
    } ctrl_t;

    function automatic logic [2:0] alu_code(input logic [OPW-1:0] op);
        case (op)
            OP_SUB:        return ALU_SUB;
            OP_OR, OP_ORI: return ALU_OR;
            OP_AND:        return ALU_AND;
            OP_SLT:        return ALU_SLT;
            default:       return ALU_ADD;
        endcase
    endfunction

    function automatic logic is_imm(input logic [OPW-1:0] op);
        return (op == OP_ADDI) || (op == OP_ORI);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath signal bundle. master = control unit, slave = datapath.
// retired_cnt exists only when PERF_CNT_EN is defined.
interface multicycle_ctrl_if;
    import cpu_ctrl_pkg::*;

    logic [OPW-1:0] opcode;
    logic           zero;
    logic           sign;
    logic [1:0]     pc_src;
    logic [1:0]     reg_dst;
    logic           pc_write;
    logic           ir_write;
    logic           reg_write;
    logic           mem_write;
    logic           alu_src_a;
    logic           alu_src_b;
    logic           ext_sel;
    logic           db_src;
    logic           wr_pc4;
    logic [2:0]     alu_op;
    logic [2:0]     state;
    logic           halted;
`ifdef PERF_CNT_EN
    logic [31:0]    retired_cnt;
`endif

    modport master (
`ifdef PERF_CNT_EN
        output retired_cnt,
`endif
        input  opcode, zero, sign,
        output pc_src, reg_dst, pc_write, ir_write, reg_write, mem_write,
               alu_src_a, alu_src_b, ext_sel, db_src, wr_pc4, alu_op, state, halted
    );

    modport slave (
`ifdef PERF_CNT_EN
        input  retired_cnt,
`endif
        output opcode, zero, sign,
        input  pc_src, reg_dst, pc_write, ir_write, reg_write, mem_write,
               alu_src_a, alu_src_b, ext_sel, db_src, wr_pc4, alu_op, state, halted
    );

endinterface

// File: rtl/ctrl_decode.sv
// Purely combinational decode: (state, opcode, zero, sign) -> control word and next state.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t         state,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    input  logic           sign,
    output ctrl_t          ctrl,
    output state_t         next_state
);

    // sign is part of the datapath status bus but no instruction here branches on it
    logic w_unused_sign;
    assign w_unused_sign = sign;

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        ctrl       = '0;
        next_state = state;
        case (state)
            S_IF: begin
                ctrl.ir_write = 1'b1;
                next_state    = S_ID;
            end
            S_ID: begin
                case (opcode)
                    OP_J: begin
                        ctrl.pc_src   = PC_JMP;
                        ctrl.pc_write = 1'b1;
                        next_state    = S_IF;
                    end
                    OP_JR: begin
                        ctrl.pc_src   = PC_JR;
                        ctrl.pc_write = 1'b1;
                        next_state    = S_IF;
                    end
                    OP_JAL: begin
                        ctrl.reg_dst   = RD_RA;
                        ctrl.wr_pc4    = 1'b1;
                        ctrl.reg_write = 1'b1;
                        ctrl.pc_src    = PC_JMP;
                        ctrl.pc_write  = 1'b1;
                        next_state     = S_IF;
                    end
                    OP_HALT: begin
                        ctrl.halted = 1'b1;
                        next_state  = S_ID;
                    end
                    OP_BEQ, OP_BNE: next_state = S_EXE_BR;
                    OP_SW, OP_LW:   next_state = S_EXE_LS;
                    OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_SLT:
                                    next_state = S_EXE_AL;
                    default: begin
                        ctrl.pc_write = 1'b1;
                        next_state    = S_IF;
                    end
                endcase
            end
            S_EXE_AL: begin
                ctrl.alu_op    = alu_code(opcode);
                ctrl.alu_src_b = is_imm(opcode);
                ctrl.ext_sel   = (opcode != OP_ORI);
                next_state     = S_WB_AL;
            end
            S_WB_AL: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = is_imm(opcode) ? RD_RT : RD_RD;
                ctrl.pc_write  = 1'b1;
                next_state     = S_IF;
            end
            S_EXE_BR: begin
                ctrl.alu_op   = ALU_SUB;
                ctrl.pc_write = 1'b1;
                if (((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero))
                    ctrl.pc_src = PC_BR;
                next_state = S_IF;
            end
            S_EXE_LS: begin
                ctrl.alu_op    = ALU_ADD;
                ctrl.alu_src_b = 1'b1;
                ctrl.ext_sel   = 1'b1;
                next_state     = S_MEM;
            end
            S_MEM: begin
                if (opcode == OP_SW) begin
                    ctrl.mem_write = 1'b1;
                    ctrl.pc_write  = 1'b1;
                    next_state     = S_IF;
                end else begin
                    next_state = S_WB_LD;
                end
            end
            S_WB_LD: begin
                ctrl.reg_write = 1'b1;
                ctrl.db_src    = 1'b1;
                ctrl.reg_dst   = RD_RT;
                ctrl.pc_write  = 1'b1;
                next_state     = S_IF;
            end
            default: next_state = S_IF;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control unit: state register, reset gating of the decoded
// control word, and the optional retired-instruction counter (PERF_CNT_EN).
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
(
    input  logic              CLK,
    input  logic              Reset,
    multicycle_ctrl_if.master bus
);

    state_t r_state;
    state_t w_next;
    ctrl_t  w_dec;
    ctrl_t  w_ctrl;

    ctrl_decode u_decode (
        .state      (r_state),
        .opcode     (bus.opcode),
        .zero       (bus.zero),
        .sign       (bus.sign),
        .ctrl       (w_dec),
        .next_state (w_next)
    );

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (Reset) r_state <= S_IF;
        else       r_state <= w_next;
    end

    // Reset masks the word combinationally so an aborted instruction writes nothing.
    assign w_ctrl = Reset ? '0 : w_dec;

    assign bus.pc_src    = w_ctrl.pc_src;
    assign bus.reg_dst   = w_ctrl.reg_dst;
    assign bus.pc_write  = w_ctrl.pc_write;
    assign bus.ir_write  = w_ctrl.ir_write;
    assign bus.reg_write = w_ctrl.reg_write;
    assign bus.mem_write = w_ctrl.mem_write;
    assign bus.alu_src_a = w_ctrl.alu_src_a;
    assign bus.alu_src_b = w_ctrl.alu_src_b;
    assign bus.ext_sel   = w_ctrl.ext_sel;
    assign bus.db_src    = w_ctrl.db_src;
    assign bus.wr_pc4    = w_ctrl.wr_pc4;
    assign bus.alu_op    = w_ctrl.alu_op;
    assign bus.halted    = w_ctrl.halted;
    assign bus.state     = Reset ? 3'd0 : r_state;

`ifdef PERF_CNT_EN
    logic [31:0] r_retired_cnt;

    always_ff @(posedge CLK) begin
        if (Reset)               r_retired_cnt <= '0;
        else if (w_ctrl.pc_write) r_retired_cnt <= r_retired_cnt + 32'd1;
    end

    assign bus.retired_cnt = r_retired_cnt;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, scoreboarded bench for multicycle_ctrl: expected control words are
// queued per cycle and compared against the DUT at the falling clock edge.
module tb_multicycle_ctrl;

    localparam logic [5:0] ADD  = 6'b000000;
    localparam logic [5:0] ADDI = 6'b000010;
    localparam logic [5:0] ORI  = 6'b010010;
    localparam logic [5:0] SLT  = 6'b100110;
    localparam logic [5:0] SW   = 6'b110000;
    localparam logic [5:0] LW   = 6'b110001;
    localparam logic [5:0] BEQ  = 6'b110100;
    localparam logic [5:0] BNE  = 6'b110101;
    localparam logic [5:0] J    = 6'b111000;
    localparam logic [5:0] JR   = 6'b111001;
    localparam logic [5:0] JAL  = 6'b111010;
    localparam logic [5:0] HALT = 6'b111111;
    localparam logic [5:0] UNK  = 6'b001111;

    typedef struct packed {
        logic [2:0] state;
        logic [1:0] pc_src;
        logic [1:0] reg_dst;
        logic       pc_write;
        logic       ir_write;
        logic       reg_write;
        logic       mem_write;
        logic       alu_src_a;
        logic       alu_src_b;
        logic       ext_sel;
        logic       db_src;
        logic       wr_pc4;
        logic [2:0] alu_op;
        logic       halted;
    } obs_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   exp_cnt;

    obs_t  exp_q[$];
    string tag_q[$];

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .CLK   (clk),
        .Reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic obs_t mk(input logic [2:0] st, input logic [1:0] pcs, input logic [1:0] rd,
                                input logic pcw, input logic irw, input logic rgw, input logic mmw,
                                input logic sb, input logic ext, input logic db, input logic pc4,
                                input logic [2:0] alu, input logic hl);
        obs_t o;
        o = '{state: st, pc_src: pcs, reg_dst: rd, pc_write: pcw, ir_write: irw,
              reg_write: rgw, mem_write: mmw, alu_src_a: 1'b0, alu_src_b: sb,
              ext_sel: ext, db_src: db, wr_pc4: pc4, alu_op: alu, halted: hl};
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o = '{state: bus.state, pc_src: bus.pc_src, reg_dst: bus.reg_dst,
              pc_write: bus.pc_write, ir_write: bus.ir_write, reg_write: bus.reg_write,
              mem_write: bus.mem_write, alu_src_a: bus.alu_src_a, alu_src_b: bus.alu_src_b,
              ext_sel: bus.ext_sel, db_src: bus.db_src, wr_pc4: bus.wr_pc4,
              alu_op: bus.alu_op, halted: bus.halted};
        return o;
    endfunction

    // Drive one cycle of inputs, queue the expected word, check it mid-cycle.
    task automatic step(input string tag, input logic rst, input logic [5:0] op,
                        input logic z, input obs_t e);
        obs_t  got;
        obs_t  want;
        string t;
        reset      = rst;
        bus.opcode = op;
        bus.zero   = z;
        bus.sign   = ~z;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        got  = sample();
        want = exp_q.pop_front();
        t    = tag_q.pop_front();
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", t, got, want);
        end
        if (rst)                exp_cnt = 0;
        else if (want.pc_write) exp_cnt++;
        @(posedge clk);
        #1;
    endtask

    obs_t E_RST, E_IF, E_ID, E_LS;

    initial begin
        checks     = 0;
        errors     = 0;
        exp_cnt    = 0;
        reset      = 1'b1;
        bus.opcode = ADD;
        bus.zero   = 1'b0;
        bus.sign   = 1'b0;
        E_RST = '0;
        E_IF  = mk(3'd0, 2'd0, 2'd0, 0, 1, 0, 0, 0, 0, 0, 0, 3'b000, 0);
        E_ID  = mk(3'd1, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
        E_LS  = mk(3'd4, 2'd0, 2'd0, 0, 0, 0, 0, 1, 1, 0, 0, 3'b000, 0);

        step("rst0", 1, ADD, 0, E_RST);
        step("rst1", 1, ADD, 0, E_RST);

        // add: IF, ID, EXE_AL, WB_AL
        step("add_if",  0, ADD, 0, E_IF);
        step("add_id",  0, ADD, 0, E_ID);
        step("add_exe", 0, ADD, 0, mk(3'd2, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 0, 0, 3'b000, 0));
        step("add_wb",  0, ADD, 0, mk(3'd6, 2'd0, 2'd2, 1, 0, 1, 0, 0, 0, 0, 0, 3'b000, 0));

        // beq taken / not taken
        step("beq1_if", 0, BEQ, 1, E_IF);
        step("beq1_id", 0, BEQ, 1, E_ID);
        step("beq1_br", 0, BEQ, 1, mk(3'd3, 2'd1, 2'd0, 1, 0, 0, 0, 0, 0, 0, 0, 3'b001, 0));
        step("beq0_if", 0, BEQ, 0, E_IF);
        step("beq0_id", 0, BEQ, 0, E_ID);
        step("beq0_br", 0, BEQ, 0, mk(3'd3, 2'd0, 2'd0, 1, 0, 0, 0, 0, 0, 0, 0, 3'b001, 0));

        // bne taken when zero=0
        step("bne_if", 0, BNE, 0, E_IF);
        step("bne_id", 0, BNE, 0, E_ID);
        step("bne_br", 0, BNE, 0, mk(3'd3, 2'd1, 2'd0, 1, 0, 0, 0, 0, 0, 0, 0, 3'b001, 0));

        // immediates and slt
        step("addi_if",  0, ADDI, 0, E_IF);
        step("addi_id",  0, ADDI, 0, E_ID);
        step("addi_exe", 0, ADDI, 0, mk(3'd2, 2'd0, 2'd0, 0, 0, 0, 0, 1, 1, 0, 0, 3'b000, 0));
        step("addi_wb",  0, ADDI, 0, mk(3'd6, 2'd0, 2'd1, 1, 0, 1, 0, 0, 0, 0, 0, 3'b000, 0));
        step("ori_if",   0, ORI, 0, E_IF);
        step("ori_id",   0, ORI, 0, E_ID);
        step("ori_exe",  0, ORI, 0, mk(3'd2, 2'd0, 2'd0, 0, 0, 0, 0, 1, 0, 0, 0, 3'b010, 0));
        step("ori_wb",   0, ORI, 0, mk(3'd6, 2'd0, 2'd1, 1, 0, 1, 0, 0, 0, 0, 0, 3'b000, 0));
        step("slt_if",   0, SLT, 0, E_IF);
        step("slt_id",   0, SLT, 0, E_ID);
        step("slt_exe",  0, SLT, 0, mk(3'd2, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 0, 0, 3'b100, 0));
        step("slt_wb",   0, SLT, 0, mk(3'd6, 2'd0, 2'd2, 1, 0, 1, 0, 0, 0, 0, 0, 3'b000, 0));

        // lw: 5 cycles; sw: 4 cycles
        step("lw_if",  0, LW, 0, E_IF);
        step("lw_id",  0, LW, 0, E_ID);
        step("lw_ls",  0, LW, 0, E_LS);
        step("lw_mem", 0, LW, 0, mk(3'd5, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0));
        step("lw_wb",  0, LW, 0, mk(3'd7, 2'd0, 2'd1, 1, 0, 1, 0, 0, 0, 1, 0, 3'b000, 0));
        step("sw_if",  0, SW, 0, E_IF);
        step("sw_id",  0, SW, 0, E_ID);
        step("sw_ls",  0, SW, 0, E_LS);
        step("sw_mem", 0, SW, 0, mk(3'd5, 2'd0, 2'd0, 1, 0, 0, 1, 0, 0, 0, 0, 3'b000, 0));

        // jumps and unknown opcode
        step("jal_if", 0, JAL, 0, E_IF);
        step("jal_id", 0, JAL, 0, mk(3'd1, 2'd2, 2'd0, 1, 0, 1, 0, 0, 0, 0, 1, 3'b000, 0));
        step("j_if",   0, J, 0, E_IF);
        step("j_id",   0, J, 0, mk(3'd1, 2'd2, 2'd0, 1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0));
        step("jr_if",  0, JR, 0, E_IF);
        step("jr_id",  0, JR, 0, mk(3'd1, 2'd3, 2'd0, 1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0));
        step("unk_if", 0, UNK, 0, E_IF);
        step("unk_id", 0, UNK, 0, mk(3'd1, 2'd0, 2'd0, 1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0));

`ifdef PERF_CNT_EN
        checks++;
        assert (bus.retired_cnt === 32'(exp_cnt)) else begin
            errors++;
            $error("FAIL retired_cnt: observed %0d expected %0d", bus.retired_cnt, exp_cnt);
        end
`endif

        // halt holds in ID until reset
        step("halt_if", 0, HALT, 0, E_IF);
        for (int i = 0; i < 20; i++)
            step("halt_id", 0, HALT, 0, mk(3'd1, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1));
        step("halt_rst", 1, HALT, 0, E_RST);
        step("post_if",  0, SW, 0, E_IF);

        // reset during sw MEM aborts it
        step("swr_id",  0, SW, 0, E_ID);
        step("swr_ls",  0, SW, 0, E_LS);
        step("swr_mem", 1, SW, 0, E_RST);
        step("swr_if",  0, ADD, 0, E_IF);

`ifdef PERF_CNT_EN
        checks++;
        assert (bus.retired_cnt === 32'(exp_cnt)) else begin
            errors++;
            $error("FAIL retired_cnt_after_rst: observed %0d expected %0d", bus.retired_cnt, exp_cnt);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
